// File: rtl/wb_stage_if.sv
// Memory-stage-to-writeback bundle: incoming instruction slot, pipeline control
// and the registered register-file write port presented by wb_stage.
interface wb_stage_if #(
  parameter int CNT_WIDTH = 64
) ();

  logic                 in_valid;
  logic                 in_reg_write;
  logic [4:0]           in_rd;
  logic [1:0]           in_wb_sel;
  logic [2:0]           in_funct3;
  logic [31:0]          in_alu_result;
  logic [31:0]          in_mem_rdata;
  logic [31:0]          in_pc_plus4;
  logic                 stall;
  logic                 flush;

  logic                 write_enable;
  logic [4:0]           write_reg;
  logic [31:0]          write_data;
  logic                 wb_valid;
  logic                 load_fault;
  logic [CNT_WIDTH-1:0] retire_count;

  modport master (
    output in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_mem_rdata, in_pc_plus4, stall, flush,
    input  write_enable, write_reg, write_data, wb_valid, load_fault,
           retire_count
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_mem_rdata, in_pc_plus4, stall, flush,
    output write_enable, write_reg, write_data, wb_valid, load_fault,
           retire_count
  );

endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register: load alignment/extension, writeback source select,
// registered register-file write port, retired-instruction counter, load faults.
module wb_stage #(
  parameter int CNT_WIDTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  wb
);

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] pick_half(input logic [31:0] w, input logic upper);
    logic [15:0] h;
    if (upper) begin
      h = w[31:16];
    end else begin
      h = w[15:0];
    end
    return h;
  endfunction

  logic                 valid_q, valid_d;
  logic                 we_q, we_d;
  logic [4:0]           reg_q, reg_d;
  logic [31:0]          data_q, data_d;
  logic                 fault_q, fault_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [1:0]  off_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_val_s;
  logic        load_bad_s;
  logic        fault_s;
  logic [31:0] sel_data_s;
  logic        we_s;
  logic        retire_s;

  // Load extraction and fault detection; a fault also forces the data to zero.
  always_comb begin
    off_s      = wb.in_alu_result[1:0];
    byte_s     = pick_byte(wb.in_mem_rdata, off_s);
    half_s     = pick_half(wb.in_mem_rdata, off_s[1]);
    load_val_s = 32'd0;
    load_bad_s = 1'b0;
    case (wb.in_funct3)
      F3_LB:  load_val_s = {{24{byte_s[7]}}, byte_s};
      F3_LBU: load_val_s = {24'd0, byte_s};
      F3_LH: begin
        if (off_s[0]) begin
          load_bad_s = 1'b1;
        end else begin
          load_val_s = {{16{half_s[15]}}, half_s};
        end
      end
      F3_LHU: begin
        if (off_s[0]) begin
          load_bad_s = 1'b1;
        end else begin
          load_val_s = {16'd0, half_s};
        end
      end
      F3_LW: begin
        if (off_s != 2'd0) begin
          load_bad_s = 1'b1;
        end else begin
          load_val_s = wb.in_mem_rdata;
        end
      end
      default: load_bad_s = 1'b1;
    endcase

    fault_s = (wb.in_wb_sel == WB_LOAD) && load_bad_s;

    case (wb.in_wb_sel)
      WB_ALU:  sel_data_s = wb.in_alu_result;
      WB_LOAD: sel_data_s = fault_s ? 32'd0 : load_val_s;
      WB_PC4:  sel_data_s = wb.in_pc_plus4;
      default: sel_data_s = 32'd0;
    endcase

    we_s = wb.in_valid && wb.in_reg_write && (wb.in_rd != 5'd0) &&
           !fault_s && (wb.in_wb_sel != 2'd3);
  end

  // Next-state selection: flush beats stall beats capture; retire on departure.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    reg_d   = reg_q;
    data_d  = data_q;
    fault_d = fault_q;
    if (wb.flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      fault_d = 1'b0;
    end else if (wb.stall) begin
      valid_d = valid_q;
      we_d    = we_q;
    end else begin
      valid_d = wb.in_valid;
      we_d    = we_s;
      reg_d   = wb.in_rd;
      data_d  = sel_data_s;
      fault_d = wb.in_valid && fault_s;
    end

    retire_s = valid_q && !fault_q && (!wb.stall || wb.flush);
    if (retire_s) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      reg_q   <= 5'd0;
      data_q  <= 32'd0;
      fault_q <= 1'b0;
      cnt_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb.wb_valid     = valid_q;
  assign wb.write_enable = we_q;
  assign wb.write_reg    = reg_q;
  assign wb.write_data   = data_q;
  assign wb.load_fault   = fault_q;
  assign wb.retire_count = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table, directed multi-cycle sequences
// and randomized traffic compared against a behavioural model.
module tb_wb_stage;

  localparam int CW = 3;
  localparam logic [31:0] M = 32'h80FF_7F01;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  wb_stage_if #(.CNT_WIDTH(CW)) bus ();

  wb_stage #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_rd         = rd;
    bus.in_wb_sel     = sel;
    bus.in_funct3     = f3;
    bus.in_alu_result = alu;
    bus.in_mem_rdata  = rdata;
    bus.in_pc_plus4   = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    tick();
    reset = 1'b0;
  endtask

  // Behavioural reference: returns {write_enable, load_fault, write_data}.
  function automatic logic [33:0] ref_wb(input logic v, input logic rw, input logic [4:0] rd,
                                         input logic [1:0] sel, input logic [2:0] f3,
                                         input logic [31:0] alu, input logic [31:0] rdata,
                                         input logic [31:0] pc4);
    int unsigned off;
    longint unsigned b;
    longint unsigned h;
    logic [31:0] data;
    logic flt;
    logic we;
    off  = alu % 4;
    flt  = 1'b0;
    data = 32'd0;
    if (sel == 2'd0) data = alu;
    else if (sel == 2'd2) data = pc4;
    else if (sel == 2'd1) begin
      if (f3 == 3'b010) begin
        if (off != 0) flt = 1'b1;
        else data = rdata;
      end else if (f3 == 3'b000 || f3 == 3'b100) begin
        b = (longint'(rdata) >> (8 * off)) % 256;
        if (f3 == 3'b000 && b >= 128) data = 32'(b + 64'hFFFF_FF00);
        else data = 32'(b);
      end else if (f3 == 3'b001 || f3 == 3'b101) begin
        if (off % 2 != 0) flt = 1'b1;
        else begin
          h = (longint'(rdata) >> (8 * off)) % 65536;
          if (f3 == 3'b001 && h >= 32768) data = 32'(h + 64'hFFFF_0000);
          else data = 32'(h);
        end
      end else begin
        flt = 1'b1;
      end
    end
    if (flt) data = 32'd0;
    we = v && rw && (rd != 5'd0) && !flt && (sel != 2'd3);
    return {we, v && flt, data};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 64'(bus.wb_valid), 64'd0);
    check({tag, ".we"},    64'(bus.write_enable), 64'd0);
    check({tag, ".reg"},   64'(bus.write_reg), 64'd0);
    check({tag, ".data"},  64'(bus.write_data), 64'd0);
    check({tag, ".fault"}, 64'(bus.load_fault), 64'd0);
    check({tag, ".cnt"},   64'(bus.retire_count), 64'd0);
  endtask

  initial begin
    logic        m_valid, m_we, m_fault, m_known;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_cnt;
    logic [33:0] r;
    logic        iv, irw;
    logic [4:0]  ird;
    logic [1:0]  isel;
    logic [2:0]  if3;
    logic [31:0] ialu, irdata, ipc4;

    errors = 0;
    checks = 0;

    tbl[0]  = '{3'b000, 2'd1, 5'd3,  32'h0000_0001, M, 32'd0,     1'b1, 32'h0000_007F, 1'b0};
    tbl[1]  = '{3'b000, 2'd1, 5'd3,  32'h0000_0002, M, 32'd0,     1'b1, 32'hFFFF_FFFF, 1'b0};
    tbl[2]  = '{3'b100, 2'd1, 5'd4,  32'h0000_0003, M, 32'd0,     1'b1, 32'h0000_0080, 1'b0};
    tbl[3]  = '{3'b001, 2'd1, 5'd6,  32'h0000_0002, M, 32'd0,     1'b1, 32'hFFFF_80FF, 1'b0};
    tbl[4]  = '{3'b101, 2'd1, 5'd7,  32'h0000_0000, M, 32'd0,     1'b1, 32'h0000_7F01, 1'b0};
    tbl[5]  = '{3'b010, 2'd1, 5'd8,  32'h0000_1000, M, 32'd0,     1'b1, 32'h80FF_7F01, 1'b0};
    tbl[6]  = '{3'b010, 2'd1, 5'd9,  32'h0000_1002, M, 32'd0,     1'b0, 32'h0000_0000, 1'b1};
    tbl[7]  = '{3'b110, 2'd1, 5'd10, 32'h0000_0000, M, 32'd0,     1'b0, 32'h0000_0000, 1'b1};
    tbl[8]  = '{3'b000, 2'd0, 5'd0,  32'h0000_1234, M, 32'd0,     1'b0, 32'h0000_1234, 1'b0};
    tbl[9]  = '{3'b000, 2'd2, 5'd1,  32'h0000_0040, M, 32'h104,   1'b1, 32'h0000_0104, 1'b0};
    tbl[10] = '{3'b000, 2'd0, 5'd5,  32'h1234_5678, M, 32'd0,     1'b1, 32'h1234_5678, 1'b0};
    tbl[11] = '{3'b000, 2'd3, 5'd5,  32'h1234_5678, M, 32'h104,   1'b0, 32'h0000_0000, 1'b0};
    tbl[12] = '{3'b001, 2'd1, 5'd11, 32'h0000_0001, M, 32'd0,     1'b0, 32'h0000_0000, 1'b1};
    tbl[13] = '{3'b011, 2'd1, 5'd12, 32'h0000_0000, M, 32'd0,     1'b0, 32'h0000_0000, 1'b1};
    tbl[14] = '{3'b110, 2'd0, 5'd13, 32'h0000_0055, M, 32'd0,     1'b1, 32'h0000_0055, 1'b0};
    tbl[15] = '{3'b101, 2'd1, 5'd14, 32'h0000_0002, M, 32'd0,     1'b1, 32'h0000_80FF, 1'b0};
    tbl[16] = '{3'b000, 2'd1, 5'd15, 32'h0000_0000, M, 32'd0,     1'b1, 32'h0000_0001, 1'b0};

    do_reset();
    check_zero("reset");

    // ALU writeback then retire
    drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'd0, 32'd0);
    tick();
    check("alu.we",    64'(bus.write_enable), 64'd1);
    check("alu.reg",   64'(bus.write_reg), 64'd5);
    check("alu.data",  64'(bus.write_data), 64'h1234_5678);
    check("alu.valid", 64'(bus.wb_valid), 64'd1);
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("alu.cnt", 64'(bus.retire_count), 64'd1);
    check("bubble.valid", 64'(bus.wb_valid), 64'd0);

    // Vector table
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, tbl[i].rd, tbl[i].sel, tbl[i].f3, tbl[i].alu, tbl[i].rdata, tbl[i].pc4);
      tick();
      check($sformatf("vec%0d.valid", i), 64'(bus.wb_valid), 64'd1);
      check($sformatf("vec%0d.reg", i),   64'(bus.write_reg), 64'(tbl[i].rd));
      check($sformatf("vec%0d.we", i),    64'(bus.write_enable), 64'(tbl[i].exp_we));
      check($sformatf("vec%0d.data", i),  64'(bus.write_data), 64'(tbl[i].exp_data));
      check($sformatf("vec%0d.fault", i), 64'(bus.load_fault), 64'(tbl[i].exp_fault));
    end

    // Faulted loads do not retire
    do_reset();
    drive(1'b1, 1'b1, 5'd9, 2'd1, 3'b010, 32'h0000_1002, M, 32'd0);
    tick();
    drive(1'b1, 1'b1, 5'd9, 2'd1, 3'b110, 32'h0000_0000, M, 32'd0);
    tick();
    check("fault2.fault", 64'(bus.load_fault), 64'd1);
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("fault.cnt", 64'(bus.retire_count), 64'd0);

    // Stall holds for three cycles, then stall+flush retires and empties
    do_reset();
    drive(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'hA5A5_0001, 32'd0, 32'd0);
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(20 + i), 2'd2, 3'd0, 32'(i), 32'd0, 32'hDEAD_0000);
      tick();
      check($sformatf("stall%0d.reg", i),  64'(bus.write_reg), 64'd7);
      check($sformatf("stall%0d.data", i), 64'(bus.write_data), 64'hA5A5_0001);
      check($sformatf("stall%0d.we", i),   64'(bus.write_enable), 64'd1);
      check($sformatf("stall%0d.cnt", i),  64'(bus.retire_count), 64'd0);
    end
    bus.flush = 1'b1;
    tick();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    check("sflush.valid", 64'(bus.wb_valid), 64'd0);
    check("sflush.we",    64'(bus.write_enable), 64'd0);
    check("sflush.cnt",   64'(bus.retire_count), 64'd1);

    // Counter wrap at CNT_WIDTH=3
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 2'd0, 3'd0, 32'(i), 32'd0, 32'd0);
      tick();
    end
    check("wrap.cnt7", 64'(bus.retire_count), 64'd7);
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("wrap.cnt0", 64'(bus.retire_count), 64'd0);

    // Reset during a stall with a valid instruction
    drive(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h0000_00AA, 32'd0, 32'd0);
    tick();
    check("rst_stall.pre", 64'(bus.wb_valid), 64'd1);
    bus.stall = 1'b1;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    bus.stall = 1'b0;
    check_zero("rst_stall");

    // Randomized traffic against the behavioural model
    do_reset();
    m_valid = 1'b0; m_we = 1'b0; m_fault = 1'b0; m_known = 1'b1;
    m_reg = 5'd0; m_data = 32'd0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      iv     = ($urandom_range(0, 3) != 0);
      irw    = ($urandom_range(0, 4) != 0);
      ird    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      isel   = 2'($urandom);
      if3    = 3'($urandom);
      ialu   = $urandom;
      irdata = $urandom;
      ipc4   = $urandom;
      drive(iv, irw, ird, isel, if3, ialu, irdata, ipc4);
      reset     = ($urandom_range(0, 39) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 6) == 0);

      if (reset) begin
        m_valid = 1'b0; m_we = 1'b0; m_fault = 1'b0; m_known = 1'b1;
        m_reg = 5'd0; m_data = 32'd0; m_cnt = 0;
      end else begin
        if (m_valid && !m_fault && (!bus.stall || bus.flush)) m_cnt = (m_cnt + 1) % 8;
        if (bus.flush) begin
          m_valid = 1'b0; m_we = 1'b0; m_fault = 1'b0; m_known = 1'b0;
        end else if (!bus.stall) begin
          r       = ref_wb(iv, irw, ird, isel, if3, ialu, irdata, ipc4);
          m_valid = iv;
          m_we    = r[33];
          m_fault = r[32];
          m_data  = r[31:0];
          m_reg   = ird;
          m_known = iv;
        end
      end

      tick();
      check("rnd.valid", 64'(bus.wb_valid), 64'(m_valid));
      check("rnd.we",    64'(bus.write_enable), 64'(m_we));
      check("rnd.fault", 64'(bus.load_fault), 64'(m_fault));
      check("rnd.cnt",   64'(bus.retire_count), 64'(m_cnt));
      if (m_known) begin
        check("rnd.reg",  64'(bus.write_reg), 64'(m_reg));
        check("rnd.data", 64'(bus.write_data), 64'(m_data));
      end
    end
    reset     = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
